// File: rtl/main_memory_ctrl.sv
// Main memory with separate instruction/data banks behind a valid/ready request port.
// Serial accesses with programmable wait states, one-cycle response pulse, instruction preload.
module main_memory_ctrl #(
  parameter int unsigned       DATA_W    = 13,
  parameter int unsigned       ADDR_W    = 4,
  parameter int unsigned       DEPTH     = 13,
  parameter int unsigned       WAIT_CYC  = 1,
  parameter logic [DATA_W-1:0] WORD0_RST = '1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_instr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);

  localparam int unsigned       CNT_W    = 4;
  localparam int unsigned       IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'((WAIT_CYC > 0) ? (WAIT_CYC - 1) : 0);
  localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               accept;

  logic               lat_write;
  logic               lat_instr;
  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_wdata;

  logic [DATA_W-1:0]  data_mem  [DEPTH];
  logic [DATA_W-1:0]  instr_mem [DEPTH];

  logic               acc_in_range;
  logic               acc_err;
  logic [DATA_W-1:0]  rd_word;
  logic               do_dwrite;
  logic               load_in_range;
  logic               do_load;

  // Preload owns the port while asserted; nothing is accepted during reset.
  assign req_ready = (state == S_IDLE) && !load_en && !reset;

  // State and wait counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          accept = 1'b1;
          if (WAIT_CYC > 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_LOAD;
          end else begin
            state_nxt = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_nxt = S_RESP;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Request fields held for the whole access
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_write <= 1'b0;
      lat_instr <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_write <= req_write;
      lat_instr <= req_instr;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  // Access decode on the latched request
  always_comb begin
    acc_in_range = ({1'b0, lat_addr} < DEPTH_V);
    acc_err      = !acc_in_range || (lat_write && lat_instr);
    rd_word      = '0;
    if (acc_in_range) begin
      rd_word = lat_instr ? instr_mem[IDX_W'(lat_addr)] : data_mem[IDX_W'(lat_addr)];
    end
    do_dwrite     = (state == S_RESP) && acc_in_range && lat_write && !lat_instr;
    load_in_range = ({1'b0, load_addr} < DEPTH_V);
    do_load       = (state == S_IDLE) && load_en && load_in_range && !reset;
  end

  // Response registers; payload holds until the next completed access
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= (state == S_RESP);
      if (state == S_RESP) begin
        resp_err   <= acc_err;
        resp_rdata <= (acc_err || lat_write) ? '0 : rd_word;
      end
    end
  end

  // Data bank: reset to a known image, written on RESP exit
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_mem[i] <= (i == 0) ? WORD0_RST : '0;
      end
    end else if (do_dwrite) begin
      data_mem[IDX_W'(lat_addr)] <= lat_wdata;
    end
  end

  // Instruction bank: preload only, contents survive reset
  always_ff @(posedge clk) begin
    if (do_load) begin
      instr_mem[IDX_W'(load_addr)] <= load_data;
    end
  end

endmodule
